score_display_ctrl: RTL and testbench

Converts a binary game score into four BCD digits with a sequential double-dabble (shift-add-3) engine. It then time-multiplexes those digits onto a shared 4-digit common-anode 7-segment display. The block drives one BCD nibble at a time into the downstream BCD-to-7-segment decoder, and drives the matching active-low digit-select lines. It sits between the Tetris score counter and the board display pins.

---
 rtl/score_display_ctrl_if.sv | 25 ++
 rtl/score_display_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_score_display_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/score_display_ctrl_if.sv
// Score/display bundle between the score counter, this controller and the segment decoder.
// Latency: n/a (signal bundle only).
// Backpressure: none; score_load is a single-cycle request, busy/done report progress.
//   master: drives score/score_load, observes digit_bcd/an/busy/done
//   slave : the display controller
interface score_display_ctrl_if #(
  parameter int SCORE_W = 14
);
  logic [SCORE_W-1:0] score;      // binary score, sampled only with score_load
  logic               score_load; // single-cycle convert-and-display request
  logic [3:0]         digit_bcd;  // BCD nibble of the selected digit
  logic [3:0]         an;         // active-low digit select, an[0]=ones
  logic               busy;       // conversion in progress
  logic               done;       // one-cycle pulse when new digits become visible

  modport master (
    output score, score_load,
    input  digit_bcd, an, busy, done
  );

  modport slave (
    input  score, score_load,
    output digit_bcd, an, busy, done
  );
endinterface

// File: rtl/score_display_ctrl.sv
// Binary score -> 4 BCD digits (sequential double-dabble) -> multiplexed common-anode display scan.
// Latency: display regs and done update SCORE_W+1 edges after the score_load edge; scan outputs registered.
// Backpressure: none; loads arriving while busy park in a one-deep pending slot (last value wins).
//   Ports: clk, rst (sync, active-high); bus (slave): score/score_load in,
//          digit_bcd/an/busy/done out.
module score_display_ctrl #(
  parameter int SCORE_W  = 14,
  parameter int SCAN_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  score_display_ctrl_if.slave  bus
);

  localparam int CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SCORE_W - 1);
  localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(9999);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_UPDATE
  } state_t;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] bin_q, bin_d;          // binary shift register
  logic [15:0]        bcd_q, bcd_d;          // BCD accumulator
  logic [CNT_W-1:0]   cnt_q, cnt_d;          // shifts done so far
  logic               pend_q, pend_d;
  logic [SCORE_W-1:0] pend_val_q, pend_val_d;
  logic [15:0]        disp_q, disp_d;        // D3..D0 as shown on the display
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0]         digit_q, digit_d;
  logic [3:0]         an_q, an_d;

  logic [SCORE_W-1:0] score_clamped;
  logic [15:0]        bcd_adj;
  logic               blank;

  // Four BCD digits can only hold 9999, so larger scores saturate.
  always_comb begin
    score_clamped = bus.score;
    if (32'(bus.score) > 32'd9999) begin
      score_clamped = SCORE_MAX;
    end
  end

  // Shift-add-3 correction: any nibble >= 5 would overflow past 9 when doubled.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM next-state logic.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    disp_d     = disp_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.score_load) begin
          bin_d   = score_clamped;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_CONVERT;
        end
      end

      S_CONVERT: begin
        // {bcd,bin} shifted left by one after the correction step.
        bcd_d = (bcd_adj << 1) | {15'd0, bin_q[SCORE_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_UPDATE;
        end
        if (bus.score_load) begin
          pend_d     = 1'b1;
          pend_val_d = score_clamped;
        end
      end

      S_UPDATE: begin
        disp_d = bcd_q;
        done_d = 1'b1;
        if (pend_q) begin
          // Chain straight into the parked value; a load this cycle re-arms pending.
          bin_d   = pend_val_q;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_CONVERT;
          pend_d  = bus.score_load;
          if (bus.score_load) begin
            pend_val_d = score_clamped;
          end
        end else if (bus.score_load) begin
          // Load coinciding with UPDATE is treated as pending and consumed at once.
          bin_d   = score_clamped;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_CONVERT;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Display scan: free-running prescaler, index, and registered digit/anode drive.
  // Outputs are computed from next-cycle index and display so they track both.
  always_comb begin
    if (presc_q == PRE_LAST) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end else begin
      presc_d = presc_q + PRE_W'(1);
      idx_d   = idx_q;
    end

    // Leading-zero blanking: slot i is dark when Di..D3 are all zero; ones never blank.
    case (idx_d)
      2'd1:    blank = (disp_d[15:4]  == 12'd0);
      2'd2:    blank = (disp_d[15:8]  == 8'd0);
      2'd3:    blank = (disp_d[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase

    if (blank) begin
      digit_d = 4'd0;
      an_d    = 4'b1111;
    end else begin
      digit_d = disp_d[{idx_d, 2'b00} +: 4];
      an_d    = ~(4'b0001 << idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      disp_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      presc_q    <= '0;
      idx_q      <= 2'd0;
      digit_q    <= 4'd0;
      an_q       <= 4'b1110;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      disp_q     <= disp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      digit_q    <= digit_d;
      an_q       <= an_d;
    end
  end

  assign bus.digit_bcd = digit_q;
  assign bus.an        = an_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl: directed scenarios plus random loads/resets,
// every cycle compared against a transaction-level model using decimal arithmetic.
module tb_score_display_ctrl;

  localparam int SCORE_W  = 14;
  localparam int SCAN_DIV = 4;
  localparam int LAT      = SCORE_W + 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  score_display_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

  score_display_ctrl #(
    .SCORE_W (SCORE_W),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Reference model state
  int m_k;        // edges since reset released (drives scan position)
  int m_disp;     // displayed decimal value
  bit m_busy;
  bit m_done;
  bit m_active;   // a conversion is in flight
  int m_end;      // edge number at which it becomes visible
  int m_val;
  bit m_pv;
  int m_pval;

  int edge_n   = 0;
  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  function automatic int clampv(input int s);
    return (s > 9999) ? 9999 : s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_edge(input bit r, input bit ld, input int sc);
    if (r) begin
      m_k = 0; m_disp = 0; m_busy = 0; m_done = 0; m_active = 0; m_pv = 0;
      return;
    end
    m_k++;
    m_done = 0;
    if (m_active && edge_n == m_end) begin
      m_disp = m_val;
      m_done = 1;
      if (m_pv) begin
        m_val = m_pval;
        m_end = edge_n + LAT;
        m_pv  = ld;
        if (ld) m_pval = clampv(sc);
      end else if (ld) begin
        m_val = clampv(sc);
        m_end = edge_n + LAT;
      end else begin
        m_active = 0;
      end
    end else if (m_active && ld) begin
      m_pv   = 1;
      m_pval = clampv(sc);
    end else if (!m_active && ld) begin
      m_active = 1;
      m_val    = clampv(sc);
      m_end    = edge_n + LAT;
    end
    m_busy = m_active;
  endtask

  task automatic step(input bit r, input bit ld, input int sc);
    int idx, pw, exp_dig, exp_an;
    bit blank;
    rst            = r;
    bus.score_load = ld;
    bus.score      = SCORE_W'(sc);
    @(posedge clk);
    edge_n++;
    model_edge(r, ld, sc);
    #1;
    idx   = (m_k / SCAN_DIV) % 4;
    pw    = 10 ** idx;
    blank = (idx > 0) && (m_disp < pw);
    exp_dig = blank ? 0 : (m_disp / pw) % 10;
    exp_an  = blank ? 15 : ((~(1 << idx)) & 15);
    chk("an",        32'(bus.an),        32'(exp_an));
    chk("digit_bcd", 32'(bus.digit_bcd), 32'(exp_dig));
    chk("busy",      32'(bus.busy),      32'(m_busy));
    chk("done",      32'(bus.done),      32'(m_done));
    if (bus.done === 1'b1) done_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  task automatic load(input int sc);
    step(1'b0, 1'b1, sc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.score_load = 1'b0;
    bus.score      = '0;

    // Reset and blank scan of 0000
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    idle(20);

    // Basic conversion and full scan rotation
    load(1234);
    idle(LAT + 20);

    // Leading-zero blanking and interior zeros
    load(7);
    idle(LAT + 18);
    load(1005);
    idle(LAT + 18);

    // Saturation
    load(12000);
    idle(LAT + 18);
    load(16383);
    idle(LAT + 18);

    // Pending: last load while busy wins, chained with no idle gap
    done_cnt = 0;
    load(56);
    idle(3);
    load(789);
    idle(4);
    load(321);
    idle(2 * LAT + 10);
    chk("pending_done_pulses", 32'(done_cnt), 32'd2);
    chk("pending_final_value", 32'(m_disp), 32'd321);

    // Reset during the 5th CONVERT cycle aborts the conversion
    load(4321);
    idle(4);
    done_cnt = 0;
    step(1'b1, 1'b0, 0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    idle(LAT + 5);
    chk("rst_no_done", 32'(done_cnt), 32'd0);
    load(42);
    idle(LAT + 18);

    // Random loads, bursts while busy, occasional resets
    for (int i = 0; i < 1500; i++) begin
      bit r, ld;
      int sc;
      r  = ($urandom_range(0, 299) == 0);
      ld = ($urandom_range(0, 7) == 0);
      sc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16383))
                                       : int'($urandom_range(0, 9999));
      step(r, ld, sc);
    end
    idle(LAT + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
